// File: rtl/sync_debounce_pkg.sv
// Shared types for the debounce / edge-extraction stage that follows the single-bit synchronizer.
package sync_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } debounce_state_t;

endpackage

// File: rtl/sync_debounce.sv
// Debounces an already-synchronized level. It emits a clean level, one-cycle rise/fall/glitch
// pulses and a wrapping count of accepted rising edges. All outputs are registered.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SyncData,
    output logic               DebouncedData,
    output logic               RisePulse,
    output logic               FallPulse,
    output logic               GlitchPulse,
    output logic [COUNT_W-1:0] EventCount
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("sync_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (CNT_W != $clog2(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("sync_debounce: CNT_W is derived and must not be overridden");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    debounce_state_t    state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               deb_n, rise_n, fall_n, glitch_n;
    logic [COUNT_W-1:0] count_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= STABLE_LO;
            cnt           <= '0;
            DebouncedData <= 1'b0;
            RisePulse     <= 1'b0;
            FallPulse     <= 1'b0;
            GlitchPulse   <= 1'b0;
            EventCount    <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            DebouncedData <= deb_n;
            RisePulse     <= rise_n;
            FallPulse     <= fall_n;
            GlitchPulse   <= glitch_n;
            EventCount    <= count_n;
        end
    end

    // cnt holds the number of consecutive samples already seen at the pending value.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        deb_n    = DebouncedData;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        glitch_n = 1'b0;
        count_n  = EventCount;
        case (state)
            STABLE_LO: begin
                if (SyncData) begin
                    state_n = WAIT_HI;
                    cnt_n   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!SyncData) begin
                    state_n  = STABLE_LO;
                    cnt_n    = '0;
                    glitch_n = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n = STABLE_HI;
                    cnt_n   = '0;
                    deb_n   = 1'b1;
                    rise_n  = 1'b1;
                    count_n = EventCount + COUNT_W'(1);
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!SyncData) begin
                    state_n = WAIT_LO;
                    cnt_n   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (SyncData) begin
                    state_n  = STABLE_HI;
                    cnt_n    = '0;
                    glitch_n = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n = STABLE_LO;
                    cnt_n   = '0;
                    deb_n   = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = STABLE_LO;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce with DEBOUNCE_CYCLES=4, COUNT_W=2.
module tb_sync_debounce;

    logic       clk;
    logic       reset;
    logic       SyncData;
    logic       DebouncedData;
    logic       RisePulse;
    logic       FallPulse;
    logic       GlitchPulse;
    logic [1:0] EventCount;

    int n_cmp = 0;
    int n_bad = 0;

    sync_debounce #(
        .DEBOUNCE_CYCLES(4),
        .COUNT_W        (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .SyncData     (SyncData),
        .DebouncedData(DebouncedData),
        .RisePulse    (RisePulse),
        .FallPulse    (FallPulse),
        .GlitchPulse  (GlitchPulse),
        .EventCount   (EventCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; inputs and checks both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic d, input logic r, input logic f,
                              input logic g, input logic [1:0] c);
        chk({tag, ".deb"},    DebouncedData, d);
        chk({tag, ".rise"},   RisePulse,     r);
        chk({tag, ".fall"},   FallPulse,     f);
        chk({tag, ".glitch"}, GlitchPulse,   g);
        chk({tag, ".count"},  EventCount,    c);
        chk({tag, ".excl"},   ($countones({RisePulse, FallPulse, GlitchPulse}) <= 1), 1);
    endtask

    initial begin
        reset    = 1'b1;
        SyncData = 1'b1;

        // Reset hold with a high input: nothing counted.
        repeat (5) begin
            step();
            expect_out("rst_hold", 0, 0, 0, 0, 2'd0);
        end
        reset = 1'b0;
        repeat (3) begin
            step();
            expect_out("rst_rel_wait", 0, 0, 0, 0, 2'd0);
        end
        step();
        expect_out("rst_rel_rise", 1, 1, 0, 0, 2'd1);
        step();
        expect_out("rise_after", 1, 0, 0, 0, 2'd1);

        // Falling edge from stable high.
        SyncData = 1'b0;
        repeat (3) begin
            step();
            expect_out("fall_wait", 1, 0, 0, 0, 2'd1);
        end
        step();
        expect_out("fall_acc", 0, 0, 1, 0, 2'd1);
        step();
        expect_out("fall_after", 0, 0, 0, 0, 2'd1);

        // Glitch of 3 high samples is rejected.
        SyncData = 1'b1;
        repeat (3) begin
            step();
            expect_out("glitch_wait", 0, 0, 0, 0, 2'd1);
        end
        SyncData = 1'b0;
        step();
        expect_out("glitch_hit", 0, 0, 0, 1, 2'd1);
        step();
        expect_out("glitch_after", 0, 0, 0, 0, 2'd1);

        // Reset mid-wait discards progress; a full 4 samples are needed again.
        SyncData = 1'b1;
        repeat (2) begin
            step();
            expect_out("rmw_pre", 0, 0, 0, 0, 2'd1);
        end
        reset = 1'b1;
        step();
        expect_out("rmw_rst", 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        repeat (3) begin
            step();
            expect_out("rmw_wait", 0, 0, 0, 0, 2'd0);
        end
        step();
        expect_out("rmw_rise", 1, 1, 0, 0, 2'd1);

        // Clear, then four rise/fall cycles to wrap the 2-bit count.
        SyncData = 1'b0;
        reset    = 1'b1;
        step();
        expect_out("wrap_rst", 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            SyncData = 1'b1;
            repeat (3) begin
                step();
                expect_out("wrap_rwait", 0, 0, 0, 0, 2'((k - 1) % 4));
            end
            step();
            expect_out("wrap_rise", 1, 1, 0, 0, 2'(k % 4));
            SyncData = 1'b0;
            repeat (3) begin
                step();
                expect_out("wrap_fwait", 1, 0, 0, 0, 2'(k % 4));
            end
            step();
            expect_out("wrap_fall", 0, 0, 1, 0, 2'(k % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
